// File: rtl/tcdm_bank_arbiter.sv
// rtl/tcdm_bank_arbiter.sv - round-robin request arbiter with in-order response routing for one TCDM bank
module tcdm_bank_arbiter #(
    parameter int unsigned NumIn          = 4,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter type         metadata_t     = logic,
    parameter int unsigned MaxOutstanding = 4,
    localparam int unsigned BeWidth       = DataWidth / 8
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumIn-1:0]                    req_valid_i,
    output logic [NumIn-1:0]                    req_ready_o,
    input  logic [NumIn-1:0][AddrWidth-1:0]     req_addr_i,
    input  logic [NumIn-1:0][3:0]               req_amo_i,
    input  logic [NumIn-1:0]                    req_write_i,
    input  logic [NumIn-1:0][DataWidth-1:0]     req_wdata_i,
    input  logic [NumIn-1:0][BeWidth-1:0]       req_be_i,
    input  metadata_t [NumIn-1:0]               req_meta_i,
    output logic [NumIn-1:0]                    resp_valid_o,
    input  logic [NumIn-1:0]                    resp_ready_i,
    output logic [DataWidth-1:0]                resp_rdata_o,
    output metadata_t                           resp_meta_o,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [AddrWidth-1:0]                out_addr_o,
    output logic [3:0]                          out_amo_o,
    output logic                                out_write_o,
    output logic [DataWidth-1:0]                out_wdata_o,
    output logic [BeWidth-1:0]                  out_be_o,
    output metadata_t                           out_meta_o,
    input  logic                                in_valid_i,
    output logic                                in_ready_o,
    input  logic [DataWidth-1:0]                in_rdata_i,
    input  metadata_t                           in_meta_i
);

    localparam int unsigned IdxW = $clog2(NumIn);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    logic [IdxW-1:0] rr_q, rr_d;
    logic            lock_q, lock_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0] fifo_q [MaxOutstanding];

    logic [IdxW-1:0] grant;
    logic [IdxW:0]   cand;
    logic            found;
    logic            any_valid, fifo_full, fifo_empty, push, pop;
    logic [IdxW-1:0] head;

    assign any_valid  = |req_valid_i;
    assign fifo_full  = (cnt_q == CntW'(MaxOutstanding));
    assign fifo_empty = (cnt_q == '0);
    assign head       = fifo_q[rd_ptr_q];

    // Cyclic search from rr_q; a stalled request keeps its grant via the lock.
    always_comb begin
        grant = rr_q;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NumIn; i++) begin
            cand = {1'b0, rr_q} + (IdxW+1)'(i);
            if (cand >= (IdxW+1)'(NumIn)) begin
                cand = cand - (IdxW+1)'(NumIn);
            end
            if (!found && req_valid_i[cand[IdxW-1:0]]) begin
                grant = cand[IdxW-1:0];
                found = 1'b1;
            end
        end
        if (lock_q) begin
            grant = lock_idx_q;
        end
    end

    // Full blocks grants regardless of a same-cycle pop, so the request path never sees the response path.
    assign out_valid_o = any_valid && !fifo_full && !rst_i;
    assign push        = out_valid_o && out_ready_i;
    assign req_ready_o = push ? (NumIn'(1) << grant) : '0;

    assign out_addr_o  = out_valid_o ? req_addr_i[grant]  : '0;
    assign out_amo_o   = out_valid_o ? req_amo_i[grant]   : '0;
    assign out_write_o = out_valid_o ? req_write_i[grant] : 1'b0;
    assign out_wdata_o = out_valid_o ? req_wdata_i[grant] : '0;
    assign out_be_o    = out_valid_o ? req_be_i[grant]    : '0;
    assign out_meta_o  = out_valid_o ? req_meta_i[grant]  : '0;

    assign in_ready_o   = !fifo_empty && resp_ready_i[head];
    assign resp_valid_o = (in_valid_i && !fifo_empty) ? (NumIn'(1) << head) : '0;
    assign resp_rdata_o = in_rdata_i;
    assign resp_meta_o  = in_meta_i;
    assign pop          = in_valid_i && in_ready_o;

    always_comb begin
        rr_d       = rr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        if (push) begin
            rr_d     = (grant == IdxW'(NumIn - 1)) ? '0 : grant + 1'b1;
            lock_d   = 1'b0;
            wr_ptr_d = (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
        end else if (out_valid_o) begin
            lock_d     = 1'b1;
            lock_idx_d = grant;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= grant;
        end
    end

    a_payload_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (out_valid_o && !out_ready_i) |=> $stable({out_addr_o, out_amo_o, out_write_o,
                                                   out_wdata_o, out_be_o, out_meta_o}));
    a_no_resp_when_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        in_valid_i |-> !fifo_empty);
    a_req_ready_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(req_ready_o));
    a_resp_valid_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(resp_valid_o));

endmodule
